pack_out_buffer: RTL



---
 rtl/pack_out_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pack_out_buffer.sv
// Byte-packing output buffer: gathers variable-length beats into fixed DRAM
// words and writes them row by row at strided addresses.
module pack_out_buffer #(
    parameter int IN_W       = 64,
    parameter int OUT_W      = 64,
    parameter int BUF_W      = 128,
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int ROW_STRIDE = 25,
    parameter int ROW_WORDS  = 25,
    parameter int NUM_ROWS   = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_W-1:0]           in_data,
    input  logic [$clog2(IN_W/8):0]   in_len,
    input  logic                      in_last,
    output logic                      out_we,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [ADDR_W-1:0]         out_addr,
    output logic                      done,
    output logic                      err
);

    localparam int IB     = IN_W / 8;
    localparam int OB     = OUT_W / 8;
    localparam int BB     = BUF_W / 8;
    localparam int LEN_W  = $clog2(IB) + 1;
    localparam int FILL_W = $clog2(BB) + 1;
    localparam int ROW_W  = $clog2(NUM_ROWS + 1);

    logic [BUF_W-1:0]  buf_q;
    logic [FILL_W-1:0] fill;
    logic              flush_pend;
    logic [ROW_W-1:0]  row_idx;
    logic [ADDR_W-1:0] word_idx;

    logic              push;
    logic              pop;
    logic              row_close;
    logic              err_set;
    logic [IN_W-1:0]   beat_m;
    logic [OUT_W-1:0]  word_m;
    logic [BUF_W-1:0]  buf_s;
    logic [BUF_W-1:0]  beat_ext;
    logic [BUF_W-1:0]  buf_n;
    logic [FILL_W-1:0] fill_s;
    logic [FILL_W-1:0] fill_n;

    always_comb begin
        in_ready = !flush_pend && !done &&
                   (({1'b0, fill} + (FILL_W+1)'(IB)) <= (FILL_W+1)'(BB));
        out_we   = !done && ((fill >= FILL_W'(OB)) ||
                             (flush_pend && fill != '0));
        push      = in_valid && in_ready;
        pop       = out_we && out_ready;
        row_close = flush_pend && (fill == '0) && !done;
    end

    // Bytes beyond in_len (input) and beyond fill (output) are forced to zero.
    always_comb begin
        beat_m = '0;
        for (int i = 0; i < IB; i++) begin
            if (LEN_W'(i) < in_len) begin
                beat_m[i*8 +: 8] = in_data[i*8 +: 8];
            end
        end
        word_m = '0;
        for (int i = 0; i < OB; i++) begin
            if (FILL_W'(i) < fill) begin
                word_m[i*8 +: 8] = buf_q[i*8 +: 8];
            end
        end
        out_data = word_m;
    end

    // Pop shifts first, so a same-cycle beat lands right after the residue.
    always_comb begin
        buf_s = pop ? (buf_q >> OUT_W) : buf_q;
        if (!pop) begin
            fill_s = fill;
        end else if (fill >= FILL_W'(OB)) begin
            fill_s = fill - FILL_W'(OB);
        end else begin
            fill_s = '0;
        end
        beat_ext = BUF_W'(beat_m) << {fill_s, 3'b000};
        buf_n    = push ? (buf_s | beat_ext) : buf_s;
        fill_n   = push ? (fill_s + FILL_W'(in_len)) : fill_s;
        err_set  = pop && !flush_pend &&
                   (((word_idx == ADDR_W'(ROW_WORDS - 1)) && (fill_n != '0)) ||
                    (word_idx >= ADDR_W'(ROW_WORDS)));
    end

    always_comb begin
        out_addr = ADDR_W'(BASE_ADDR) +
                   ADDR_W'(row_idx) * ADDR_W'(ROW_STRIDE) +
                   word_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            fill       <= '0;
            flush_pend <= 1'b0;
            row_idx    <= '0;
            word_idx   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else if (clear) begin
            buf_q      <= '0;
            fill       <= '0;
            flush_pend <= 1'b0;
            row_idx    <= '0;
            word_idx   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else if (row_close) begin
            flush_pend <= 1'b0;
            word_idx   <= '0;
            row_idx    <= row_idx + 1'b1;
            if (row_idx == ROW_W'(NUM_ROWS - 1)) begin
                done <= 1'b1;
            end
        end else begin
            buf_q <= buf_n;
            fill  <= fill_n;
            if (push && in_last) begin
                flush_pend <= 1'b1;
            end
            if (pop) begin
                word_idx <= word_idx + 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule
